hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/mips_pkg.sv | 32 +++
 rtl/hazard_div_timer.sv | 35 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, hazard FSM state encoding and hazard helpers
// used by hazard_ctrl and its divide timer.
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } hz_state_e;

  // A load in EX whose destination feeds either source of the ID instruction;
  // r0 is never a real dependency.
  function automatic logic load_use_hit(input logic [5:0] ex_op,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return (ex_op == OP_LW) && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  function automatic logic is_div(input logic [5:0] ex_op,
                                  input logic [5:0] ex_fn);
    return (ex_op == OP_RTYPE) && (ex_fn == FN_DIV);
  endfunction

endpackage

// File: rtl/hazard_div_timer.sv
// Divide stall timer: loads a cycle count, decrements on request and flags the
// last wait cycle (count == 1).
module hazard_div_timer
  import mips_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: taken-branch flush, load-use bubble and, when
// HAZARD_DIV_STALL_EN is defined, a multi-cycle divide stall FSM.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_LATENCY = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  ID_OpCode,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [5:0]  EX_OpCode,
  input  logic [5:0]  EX_Funct,
  input  logic [4:0]  EX_Rt,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        FlushRegisters,
  output logic        ID_EX_Hold,
  output logic        DivBusy,
  output logic [15:0] StallCount,
  output logic [1:0]  dbg_state
);

  logic        load_use;
  logic [15:0] stall_count_q, stall_count_d;

  assign load_use = load_use_hit(EX_OpCode, EX_Rt, ID_Rs, ID_Rt);

`ifdef HAZARD_DIV_STALL_EN
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  hz_state_e state_q, state_d;
  logic      tmr_load, tmr_dec, tmr_done;
  logic      unused_in;

  assign unused_in = ^ID_OpCode;

  hazard_div_timer u_div_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (DIV_LOAD),
    .done     (tmr_done)
  );

  always_comb begin
    PCWrite        = 1'b1;
    IF_ID_Write    = 1'b1;
    IF_ID_Flush    = 1'b0;
    FlushRegisters = 1'b0;
    ID_EX_Hold     = 1'b0;
    DivBusy        = 1'b0;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    state_d        = state_q;
    case (state_q)
      RUN: begin
        if (BranchTaken) begin
          IF_ID_Flush    = 1'b1;
          FlushRegisters = 1'b1;
        end else if (is_div(EX_OpCode, EX_Funct)) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Hold  = 1'b1;
          DivBusy     = 1'b1;
          tmr_load    = 1'b1;
          state_d     = DIV_WAIT;
        end else if (load_use) begin
          PCWrite        = 1'b0;
          IF_ID_Write    = 1'b0;
          FlushRegisters = 1'b1;
        end
      end
      DIV_WAIT: begin
        // The detection cycle is stall #1, so the wait covers the remaining
        // DIV_LATENCY-1 cycles.
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Hold  = 1'b1;
        DivBusy     = 1'b1;
        tmr_dec     = 1'b1;
        if (tmr_done) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // The divide is still sitting in ID/EX here, so it must not re-trigger.
        if (BranchTaken) begin
          IF_ID_Flush    = 1'b1;
          FlushRegisters = 1'b1;
        end else if (load_use) begin
          PCWrite        = 1'b0;
          IF_ID_Write    = 1'b0;
          FlushRegisters = 1'b1;
        end
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;
`else
  logic unused_in;

  assign unused_in = ^{ID_OpCode, EX_Funct, CNT_W'(DIV_LATENCY)};

  always_comb begin
    PCWrite        = 1'b1;
    IF_ID_Write    = 1'b1;
    IF_ID_Flush    = 1'b0;
    FlushRegisters = 1'b0;
    if (BranchTaken) begin
      IF_ID_Flush    = 1'b1;
      FlushRegisters = 1'b1;
    end else if (load_use) begin
      PCWrite        = 1'b0;
      IF_ID_Write    = 1'b0;
      FlushRegisters = 1'b1;
    end
  end

  assign ID_EX_Hold = 1'b0;
  assign DivBusy    = 1'b0;
  assign dbg_state  = RUN;
`endif

  always_comb begin
    stall_count_d = stall_count_q;
    if (!PCWrite && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with DIV_LATENCY=4; divide-stall checks
// follow HAZARD_DIV_STALL_EN like the design.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  // Expected output vectors: {PCWrite, IF_ID_Write, IF_ID_Flush, FlushRegisters, ID_EX_Hold, DivBusy}
  localparam logic [5:0] O_DEF = 6'b110000;
  localparam logic [5:0] O_BR  = 6'b111100;
  localparam logic [5:0] O_LU  = 6'b000100;
  localparam logic [5:0] O_DIV = 6'b000011;

  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_RT    = 6'b000000;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  ID_OpCode, EX_OpCode, EX_Funct;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        BranchTaken;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, FlushRegisters, ID_EX_Hold, DivBusy;
  logic [15:0] StallCount;
  logic [1:0]  dbg_state;

  logic [5:0]  exp_q[$];
  logic [15:0] stall_exp;
  int          total = 0;
  int          bad   = 0;

  hazard_ctrl #(.DIV_LATENCY(LAT)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_OpCode      (ID_OpCode),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .EX_OpCode      (EX_OpCode),
    .EX_Funct       (EX_Funct),
    .EX_Rt          (EX_Rt),
    .BranchTaken    (BranchTaken),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .FlushRegisters (FlushRegisters),
    .ID_EX_Hold     (ID_EX_Hold),
    .DivBusy        (DivBusy),
    .StallCount     (StallCount),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic [5:0] exop, input logic [5:0] exfn, input logic [4:0] exrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic br);
    EX_OpCode   = exop;
    EX_Funct    = exfn;
    EX_Rt       = exrt;
    ID_Rs       = rs;
    ID_Rt       = rt;
    BranchTaken = br;
  endtask

  task automatic set_idle();
    set_in(T_ADDI, 6'd0, 5'd9, 5'd1, 5'd2, 1'b0);
  endtask

  // Called at a negedge with inputs already set; compares outputs mid-cycle,
  // then the stall counter after the next posedge.
  task automatic step(input string tag, input logic [5:0] exp_out, input logic [1:0] exp_st);
    logic [5:0] e;
    exp_q.push_back(exp_out);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_q"}, 32'd0, 32'd1);
      e = O_DEF;
    end else begin
      e = exp_q.pop_front();
    end
    check_val({tag, "_out"},
              {26'd0, PCWrite, IF_ID_Write, IF_ID_Flush, FlushRegisters, ID_EX_Hold, DivBusy},
              {26'd0, e});
    check_val({tag, "_st"}, {30'd0, dbg_state}, {30'd0, exp_st});
    @(posedge Clk);
    if (!e[5] && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
    #1;
    check_val({tag, "_cnt"}, {16'd0, StallCount}, {16'd0, stall_exp});
    @(negedge Clk);
  endtask

  initial begin
    int tmp;
    logic [5:0] exop, e;
    logic [4:0] exrt, rs, rt;
    logic br;

    ID_OpCode = 6'd0;
    stall_exp = 16'd0;
    Reset = 1'b1;
    set_idle();
    #3;
    check_val("rst_out", {26'd0, PCWrite, IF_ID_Write, IF_ID_Flush, FlushRegisters, ID_EX_Hold, DivBusy},
              {26'd0, O_DEF});
    check_val("rst_cnt", {16'd0, StallCount}, 32'd0);
    check_val("rst_st", {30'd0, dbg_state}, {30'd0, S_RUN});
    @(negedge Clk);
    Reset = 1'b0;

    // load-use via rs, then via rt
    set_in(T_LW, 6'd0, 5'd5, 5'd5, 5'd3, 1'b0);
    step("lu_rs", O_LU, S_RUN);
    set_idle();
    step("idle1", O_DEF, S_RUN);
    set_in(T_LW, 6'd0, 5'd7, 5'd2, 5'd7, 1'b0);
    step("lu_rt", O_LU, S_RUN);
    // r0 never hazards, non-matching load passes
    set_in(T_LW, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    step("lu_r0", O_DEF, S_RUN);
    set_in(T_LW, 6'd0, 5'd4, 5'd5, 5'd6, 1'b0);
    step("lu_miss", O_DEF, S_RUN);
    // branch beats load-use
    set_in(T_LW, 6'd0, 5'd5, 5'd5, 5'd5, 1'b1);
    step("br_lu", O_BR, S_RUN);
    set_idle();
    step("idle2", O_DEF, S_RUN);

`ifdef HAZARD_DIV_STALL_EN
    // divide: LAT stall cycles, branch/load-use ignored while waiting
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("div_c1", O_DIV, S_RUN);
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b1);
    step("div_c2", O_DIV, S_WAIT);
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("div_c3", O_DIV, S_WAIT);
    step("div_c4", O_DIV, S_WAIT);
    step("div_done", O_DEF, S_DONE);
    set_idle();
    step("div_run", O_DEF, S_RUN);
    // divide beats load-use; DIV_DONE still sees load-use
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("div2_c1", O_DIV, S_RUN);
    repeat (LAT - 1) step("div2_w", O_DIV, S_WAIT);
    set_in(T_LW, 6'd0, 5'd6, 5'd6, 5'd1, 1'b0);
    step("done_lu", O_LU, S_DONE);
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b1);
    step("br_div", O_BR, S_RUN);
    // DIV_DONE with taken branch
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("div3_c1", O_DIV, S_RUN);
    repeat (LAT - 1) step("div3_w", O_DIV, S_WAIT);
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b1);
    step("done_br", O_BR, S_DONE);
    set_idle();
    step("idle3", O_DEF, S_RUN);

    // reset in the 2nd DIV_WAIT cycle
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("rdiv_c1", O_DIV, S_RUN);
    step("rdiv_c2", O_DIV, S_WAIT);
    #1;
    check_val("rdiv_busy_pre", {31'd0, DivBusy}, 32'd1);
    #2;
    Reset = 1'b1;
    set_idle();
    #1;
    check_val("rdiv_busy", {31'd0, DivBusy}, 32'd0);
    check_val("rdiv_st", {30'd0, dbg_state}, {30'd0, S_RUN});
    check_val("rdiv_cnt", {16'd0, StallCount}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    stall_exp = 16'd0;
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("div4_c1", O_DIV, S_RUN);
    repeat (LAT - 1) step("div4_w", O_DIV, S_WAIT);
    set_idle();
    step("div4_done", O_DEF, S_DONE);
`else
    // divide passes as a single-cycle op
    set_in(T_RT, F_DIV, 5'd8, 5'd8, 5'd1, 1'b0);
    step("div_pass", O_DEF, S_RUN);
    step("div_pass2", O_DEF, S_RUN);
    set_idle();
`endif

    // random RUN traffic (no divides)
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: exop = T_LW;
        1: exop = T_BEQ;
        2: exop = T_ADDI;
        default: exop = T_LW;
      endcase
      exrt = 5'($urandom_range(0, 3));
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      br   = ($urandom_range(0, 3) == 0);
      set_in(exop, F_ADD, exrt, rs, rt, br);
      if (br) e = O_BR;
      else if (exop == T_LW && exrt != 5'd0 && (exrt == rs || exrt == rt)) e = O_LU;
      else e = O_DEF;
      step("rnd", e, S_RUN);
    end

    // reset in the middle of a load-use stall clears the counter
    set_in(T_LW, 6'd0, 5'd5, 5'd5, 5'd3, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    check_val("rlu_cnt", {16'd0, StallCount}, 32'd0);
    check_val("rlu_pc", {31'd0, PCWrite}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    stall_exp = 16'd0;

    // saturate with continuous load-use stalls
    repeat (65540) @(posedge Clk);
    tmp = int'(stall_exp) + 65540;
    stall_exp = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
    @(negedge Clk);
    check_val("sat_cnt", {16'd0, StallCount}, {16'd0, stall_exp});
    step("sat_hold", O_LU, S_RUN);
    set_idle();
    step("sat_idle", O_DEF, S_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
